// File: rtl/pipe_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_reg_pkg                                                         |
// | Shared constants and helpers for the pipe_reg_nbit pipeline.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_reg_pkg;

    localparam int MAX_BUS_WIDTH = 256;

    localparam logic [MAX_BUS_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Narrower words are zero-extended by the caller, which leaves parity unchanged.
    function automatic logic even_parity(input logic [MAX_BUS_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_reg_stage                                                       |
// | One handshaked pipeline slot: valid, data and (PIPE_REG_PARITY_EN)   |
// | a stored even-parity bit.  Rev 1.0                                   |
// +----------------------------------------------------------------------+
module pipe_reg_stage
    import pipe_reg_pkg::*;
#(
    parameter int                   BUS_WIDTH   = 8,
    parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 adv,
    input  logic                 prev_valid,
    input  logic [BUS_WIDTH-1:0] prev_data,
`ifdef PIPE_REG_PARITY_EN
    input  logic                 prev_parity,
    output logic                 parity,
`endif
    output logic                 valid,
    output logic [BUS_WIDTH-1:0] data
);

    logic                 valid_d;
    logic                 valid_q;
    logic [BUS_WIDTH-1:0] data_d;
    logic [BUS_WIDTH-1:0] data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = RESET_VALUE;
        end else if (adv) begin
            valid_d = prev_valid;
            // An empty slot moving in never disturbs the held word.
            if (prev_valid) begin
                data_d = prev_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

`ifdef PIPE_REG_PARITY_EN
    localparam logic RESET_PARITY = even_parity(MAX_BUS_WIDTH'(RESET_VALUE));

    logic parity_d;
    logic parity_q;

    always_comb begin
        parity_d = parity_q;
        if (flush) begin
            parity_d = RESET_PARITY;
        end else if (adv && prev_valid) begin
            parity_d = prev_parity;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            parity_q <= RESET_PARITY;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_reg_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_reg_nbit                                                        |
// | DEPTH-stage valid/ready register pipeline with bubble collapsing and |
// | synchronous flush; PIPE_REG_PARITY_EN adds per-word parity.  Rev 1.0 |
// +----------------------------------------------------------------------+
module pipe_reg_nbit
    import pipe_reg_pkg::*;
#(
    parameter int                   BUS_WIDTH   = 8,
    parameter int                   DEPTH       = 2,
    parameter logic [BUS_WIDTH-1:0] RESET_VALUE = BUS_WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BUS_WIDTH-1:0]          in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BUS_WIDTH-1:0]          out_data,
`ifdef PIPE_REG_PARITY_EN
    output logic                          out_parity_err,
`endif
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0]     v;
    logic [DEPTH-1:0]     adv;
    logic [DEPTH-1:0]     src_valid;
    logic [BUS_WIDTH-1:0] src_data [DEPTH];
    logic [BUS_WIDTH-1:0] d        [DEPTH];
`ifdef PIPE_REG_PARITY_EN
    logic [DEPTH-1:0]     src_parity;
    logic [DEPTH-1:0]     p;
`endif

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            // Unrolled backward chain: a stage moves when any stage from it to
            // the output is empty, or the output is being consumed.
            assign adv[i] = out_ready | ~(&v[DEPTH-1:i]);

            if (i == 0) begin : g_head
                assign src_valid[i] = in_valid;
                assign src_data[i]  = in_data;
`ifdef PIPE_REG_PARITY_EN
                assign src_parity[i] = even_parity(MAX_BUS_WIDTH'(in_data));
`endif
            end else begin : g_body
                assign src_valid[i] = v[i-1];
                assign src_data[i]  = d[i-1];
`ifdef PIPE_REG_PARITY_EN
                assign src_parity[i] = p[i-1];
`endif
            end

            pipe_reg_stage #(
                .BUS_WIDTH   (BUS_WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk         (clk),
                .reset_n     (reset_n),
                .flush       (flush),
                .adv         (adv[i]),
                .prev_valid  (src_valid[i]),
                .prev_data   (src_data[i]),
`ifdef PIPE_REG_PARITY_EN
                .prev_parity (src_parity[i]),
                .parity      (p[i]),
`endif
                .valid       (v[i]),
                .data        (d[i])
            );
        end
    endgenerate

    assign in_ready  = adv[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef PIPE_REG_PARITY_EN
    assign out_parity_err = out_valid &
                            (even_parity(MAX_BUS_WIDTH'(out_data)) != p[DEPTH-1]);
`endif

    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occupancy_d;
    logic [OCC_W-1:0] occupancy_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Shifts conserve words, so tracking entries and exits equals popcount(v).
    always_comb begin
        occupancy_d = occupancy_q + OCC_W'(in_fire) - OCC_W'(out_fire);
        if (flush) begin
            occupancy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign occupancy = occupancy_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_reg_nbit                                                     |
// | Directed bench for pipe_reg_nbit with an in-order word scoreboard.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_reg_nbit;

    localparam int BW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_REG_PARITY_EN
    logic          out_parity_err;
`endif

    int checks   = 0;
    int failures = 0;
    logic [BW-1:0] exp_q[$];
    bit skip_data = 1'b0;

    always #5 clk = ~clk;

    pipe_reg_nbit #(
        .BUS_WIDTH   (BW),
        .DEPTH       (DEPTH),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
`ifdef PIPE_REG_PARITY_EN
        .out_parity_err (out_parity_err),
`endif
        .occupancy      (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven; checks the
    // handshake, updates the scoreboard, then advances one rising edge.
    task automatic cycle();
        logic [BW-1:0] w;
        #1;
        if (reset_n) begin
            chk("in_ready", in_ready, out_ready || (exp_q.size() < DEPTH));
            if (out_valid && out_ready) begin
                chk("pop_available", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    if (skip_data) skip_data = 1'b0;
                    else chk("out_data_order", out_data, w);
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(in_data);
        end else begin
            exp_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
        chk("occupancy", occupancy, exp_q.size());
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset held two edges with a word offered.
        cycle();
        cycle();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);

        // Streaming with out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h01; cycle();
        chk("stream_lat_v0", out_valid, 0);
        in_data   = 8'h02; cycle();
        chk("stream_v1", out_valid, 1);
        chk("stream_d1", out_data, 8'h01);
        in_data   = 8'h03; cycle();
        chk("stream_v2", out_valid, 1);
        chk("stream_d2", out_data, 8'h02);
        in_valid  = 1'b0;  cycle();
        chk("stream_v3", out_valid, 1);
        chk("stream_d3", out_data, 8'h03);
        cycle();
        chk("stream_empty", out_valid, 0);

        // Back-pressure: third word must be held upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h10; cycle();
        chk("bp_occ1", occupancy, 1);
        in_data   = 8'h11; cycle();
        chk("bp_occ2", occupancy, 2);
        chk("bp_full_ready", in_ready, 0);
        in_data   = 8'h12; cycle();
        chk("bp_hold_occ", occupancy, 2);
        chk("bp_hold_data", out_data, 8'h10);
        out_ready = 1'b1;  cycle();
        chk("bp_full_passthru_occ", occupancy, 2);
        in_valid  = 1'b0;  cycle();
        cycle();
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_drained_v", out_valid, 0);

        // Bubble collapse under a stalled output.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h20; cycle();
        in_valid  = 1'b0;  cycle();
        in_valid  = 1'b1;
        in_data   = 8'h21; cycle();
        in_valid  = 1'b0;
        #1;
        chk("bubble_occ", occupancy, 2);
        chk("bubble_v", out_valid, 1);
        chk("bubble_d", out_data, 8'h20);
        chk("bubble_ready", in_ready, 0);

        // Flush while full with a word offered.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55; cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", occupancy, 0);
        chk("flush_v", out_valid, 0);
        chk("flush_d", out_data, 8'h00);

        // Flush with in_ready=1: the handshake completes but the word is dropped.
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77; cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("flush_drop_v", out_valid, 0);
        end

        // Reset together with flush.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h66; cycle();
        in_valid  = 1'b0;  cycle();
        chk("pre_rst_d", out_data, 8'h66);
        reset_n   = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hAA; cycle();
        reset_n   = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        #1;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_out_data", out_data, 8'h00);
        chk("rst2_occupancy", occupancy, 0);
        chk("rst2_in_ready", in_ready, 1);

`ifdef PIPE_REG_PARITY_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h30; cycle();
        in_data   = 8'h31; cycle();
        in_valid  = 1'b0;
        #1;
        chk("par_clean", out_parity_err, 0);
        force dut.g_stage[1].u_stage.data_q = 8'h31;
        #1;
        chk("par_err", out_parity_err, 1);
        release dut.g_stage[1].u_stage.data_q;
        skip_data = 1'b1;
        out_ready = 1'b1;  cycle();
        chk("par_next_clean_d", out_data, 8'h31);
        chk("par_next_clean", out_parity_err, 0);
        cycle();
`endif

        chk("final_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_reg_nbit.md
Name: pipe_reg_nbit

Overview:
Parametrised multi-stage register pipeline with valid/ready handshake, bubble collapsing and synchronous flush. It is the successor to the single N-bit flip-flop in the A501 expansion glue logic. It carries address/data/control words across clock stages between the Amiga bus capture logic and the DRAM controller without losing or duplicating words under back-pressure.

Parameters:
BUS_WIDTH, 8, data word width in bits (>=1)
DEPTH, 2, number of register stages (>=1); unstalled latency in cycles
RESET_VALUE, 0, value loaded into every stage data register on reset or flush

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset
flush  input  1  synchronous clear of all stage valid bits
in_valid  input  1  upstream word present
in_ready  output  1  pipeline accepts the word this cycle
in_data  input  BUS_WIDTH  upstream word
out_valid  output  1  stage DEPTH-1 holds a word
out_ready  input  1  downstream consumes the word this cycle
out_data  output  BUS_WIDTH  word in stage DEPTH-1
occupancy  output  clog2(DEPTH+1)  count of valid stages

Behaviour:
- Reset: reset_n is synchronous, active-low. When reset_n=0 at a rising clk edge, all stage valid bits become 0 and all stage data registers become RESET_VALUE. Reset overrides flush and all transfers.
- After reset: out_valid=0, out_data=RESET_VALUE, occupancy=0, in_ready=1.
- Stage i holds valid v[i] and data d[i]. Stage 0 is the input stage; stage DEPTH-1 is the output stage.
- Advance condition, combinational, evaluated from the output backward:
  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready
  - adv[i] = ~v[i] | adv[i+1]
- in_ready = adv[0]. It is a combinational function of out_ready and the valid bits.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- At the clock edge, for each stage with adv[i]=1:
  - i=0: v[0] <= in_valid and d[0] <= in_data.
  - i>0: v[i] <= v[i-1] and d[i] <= d[i-1].
  - A stage with adv[i]=0 holds its state.
- Data registers load only when the incoming valid is 1. An invalid slot never overwrites data, so out_data is stable while out_valid=0.
- Bubbles collapse: a word advances into any empty downstream stage even while the output is stalled.
- Unstalled latency: a word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles from in_valid to out_valid.
- Throughput: one word per cycle when out_ready=1 continuously.
- Full (all v=1, out_ready=0): in_ready=0, all state held. When full with out_ready=1, the pipeline accepts and emits in the same cycle.
- Empty: out_valid=0. out_ready is ignored.
- flush=1 (reset_n=1): all v <= 0 at the edge. Data registers load RESET_VALUE. The same-cycle input word is dropped. in_ready remains the normal combinational value, so an upstream handshake may complete, but the word is discarded by design.
- occupancy is the registered popcount of v. It updates on the same edge as v.
- DEPTH=1 degenerates to a single handshaked register. It has no combinational in_data-to-out_data path.

Optional Feature:
Macro PIPE_REG_PARITY_EN.
- Defined:
  - Each stage carries one extra even-parity bit, computed from in_data at stage 0.
  - Adds output out_parity_err (1 bit), combinational = out_valid & (^out_data != stored parity).
  - Reset and flush clear the parity bits to the parity of RESET_VALUE.
- Undefined:
  - No parity storage and no out_parity_err port.
  - Behaviour is otherwise identical.

Decomposition:
- Package pipe_reg_pkg:
  - Function for occupancy width.
  - Function for even parity.
  - Default RESET_VALUE constant.
- Sub-module pipe_reg_stage:
  - One stage holding valid, data and optional parity.
  - Inputs: adv, prev valid/data, flush.
  - Instantiated DEPTH times in a generate loop.
  - The top level owns the adv chain and occupancy.

Test Plan:
1. Reset, DEPTH=2, BUS_WIDTH=8, RESET_VALUE=8'h00: hold reset_n=0 for 2 cycles with in_valid=1, in_data=8'hAA -> out_valid=0, out_data=8'h00, occupancy=0, in_ready=1 after release.
2. Streaming, out_ready=1: push 8'h01,8'h02,8'h03 on consecutive cycles -> out_valid rises 2 cycles after the first push; out_data sequence 01,02,03 on consecutive cycles; no gaps.
3. Back-pressure: out_ready=0 while pushing 8'h10,8'h11,8'h12 -> occupancy 1 then 2; in_ready=0 at full; third word held upstream. Release out_ready -> 10,11,12 delivered in order, none lost or duplicated.
4. Bubble collapse: push 8'h20, idle one cycle, push 8'h21, with out_ready=0 -> both stages occupied, occupancy=2, 20 at the output.
5. Flush when full with concurrent in_valid=1, in_data=8'h55 -> next cycle occupancy=0, out_valid=0, 8'h55 never emerges. Reset_n=0 asserted together with flush -> reset state.
6. With PIPE_REG_PARITY_EN: force a stage-1 data bit flip via the bench -> out_parity_err=1 while that word is at the output; the error is 0 for all unforced words.
